button_reader: RTL and testbench
================================

BUTTON_READER -- requirements
Module: button_reader

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000, giving the clocks the input must stay stable for (20 ms at 50 MHz).
REQ-002 The block SHALL have parameter LONG_CYCLES, default 50000000, giving the held clocks that qualify a long press (1 s at 50 MHz).
REQ-003 The block SHALL have parameter ACTIVE_LOW, default 1; when 1, pin level 0 means pressed.
REQ-004 The block SHALL have port clk50mhz, input, 1 bit: the single clock; all state SHALL be clocked on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port button, input, 1 bit: the raw, asynchronous, bouncing pushbutton pin.
REQ-007 The block SHALL have port pressed, output, 1 bit: the debounced level, 1 while the button is held.
REQ-008 The block SHALL have port press_pulse, output, 1 bit: one-clock strobe on a debounced press.
REQ-009 The block SHALL have port release_pulse, output, 1 bit: one-clock strobe on a debounced release.
REQ-010 The block SHALL have port long_pulse, output, 1 bit: one-clock strobe when a hold reaches LONG_CYCLES.
REQ-011 The block SHALL have port mode, output, 2 bits: the pattern-select counter consumed by the LED pattern logic.

Function
REQ-012 The button pin SHALL pass through a 2-flop synchronizer; the synchronized active signal btn_a SHALL equal the synchronized pin XOR ACTIVE_LOW.
REQ-013 The FSM SHALL have the states IDLE, DB_PRESS, HELD, LONG and DB_RELEASE.
REQ-014 IDLE SHALL behave as follows: btn_a=1 -> DB_PRESS, with the debounce counter cleared.
REQ-015 DB_PRESS SHALL behave as follows:
- btn_a=0 -> IDLE, with no output activity (glitch rejected).
- Otherwise the debounce counter SHALL increment.
- When the counter equals DEBOUNCE_CYCLES-1 with btn_a=1 -> HELD, with press_pulse=1 for one clock, pressed=1, and the hold counter cleared.
REQ-016 HELD SHALL behave as follows:
- The hold counter SHALL increment.
- When the hold counter equals LONG_CYCLES-1 -> LONG, with long_pulse=1 for one clock and mode reset to 0.
- Otherwise, btn_a=0 -> DB_RELEASE, with the debounce counter cleared.
- If btn_a=0 and the long threshold occur in the same cycle, the long transition SHALL win; the release is evaluated from LONG on the next clock.
REQ-017 LONG SHALL behave as follows: btn_a=0 -> DB_RELEASE, with the debounce counter cleared and the hold counter frozen.
REQ-018 DB_RELEASE SHALL behave as follows:
- btn_a=1 -> return to the originating state (HELD or LONG, held in a 1-bit flag), with the hold counter resumed and not cleared.
- The debounce counter SHALL increment; when it equals DEBOUNCE_CYCLES-1 with btn_a=0 -> IDLE, with release_pulse=1 for one clock and pressed=0.
- If the originating state was HELD, mode SHALL increment in that same clock, modulo 4 (3 wraps to 0).
REQ-019 A long press SHALL never increment mode on release.
REQ-020 press_pulse SHALL rise exactly DEBOUNCE_CYCLES+2 rising edges after the first edge that samples the new pin level; release_pulse SHALL use the same latency from the release edge.
REQ-021 All outputs SHALL be registered.
REQ-022 At most one of press_pulse, release_pulse and long_pulse SHALL be high in any clock.
REQ-023 The counters SHALL be $clog2-sized for their parameter and SHALL never wrap; they saturate at the compare value.
REQ-024 Elaboration SHALL fail unless DEBOUNCE_CYCLES>=2 and LONG_CYCLES>DEBOUNCE_CYCLES.

Reset
REQ-025 Asserting reset_n low SHALL force the following at any time, including mid-debounce or mid-hold, without waiting for a clock:
- FSM state IDLE.
- Both counters 0.
- Synchronizer flops to the inactive pin level (1 when ACTIVE_LOW=1).
- pressed=0, all three pulses 0, mode=0.
REQ-026 After reset_n is released with the button already held, the block SHALL require a full DEBOUNCE_CYCLES before press_pulse.

Structure
REQ-027 The FSM state encoding localparams and the mode width SHALL live in the shared package button_reader_pkg.
REQ-028 The 2-flop synchronizer SHALL be the sub-module sync2 (1 bit, async reset value as a parameter); all other logic SHALL be flat.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=20, ACTIVE_LOW=1)
REQ-029 Pin held low from edge e0 -> press_pulse high at edge e6 only, pressed=1 from e6.
REQ-030 Pin low for 3 clocks then high (bounce) -> no pulses; pressed stays 0; FSM returns to IDLE.
REQ-031 Short press then release stable -> release_pulse 6 edges after the release edge; mode 0->1; four short presses -> mode wraps to 0.
REQ-032 Hold for 30 clocks, with mode=2 at entry -> long_pulse once, 20 clocks after press_pulse; mode=0; no increment at release.
REQ-033 During HELD, a 2-clock high glitch -> no release_pulse; the hold counter continues; the long press still fires at the correct count.
REQ-034 reset_n pulsed low in DB_RELEASE with mode=3 -> all outputs 0 immediately and mode=0; then, with the pin held low, press_pulse 6 edges after reset release.

Source files
------------

// File: rtl/button_reader_pkg.sv
// Shared definitions for the pushbutton reader: FSM state encoding and the
// width of the LED pattern-select counter.
package button_reader_pkg;

  localparam int STATE_W = 3;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE       = 3'd0;
  localparam state_t ST_DB_PRESS   = 3'd1;
  localparam state_t ST_HELD       = 3'd2;
  localparam state_t ST_LONG       = 3'd3;
  localparam state_t ST_DB_RELEASE = 3'd4;

  localparam int MODE_W = 2;
  typedef logic [MODE_W-1:0] mode_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous bit; both flops reset to
// RESET_VAL so the output holds a known level straight out of reset.
module sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/button_reader.sv
// Debounced pushbutton reader: press/release/long-press strobes, a debounced
// level, and a 2-bit mode counter advanced by each short press.
module button_reader
  import button_reader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 50000000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic              clk50mhz,
  input  logic              reset_n,
  input  logic              button,
  output logic              pressed,
  output logic              press_pulse,
  output logic              release_pulse,
  output logic              long_pulse,
  output logic [MODE_W-1:0] mode
);

  if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_params
    $error("button_reader: need DEBOUNCE_CYCLES >= 2 and LONG_CYCLES > DEBOUNCE_CYCLES");
  end

  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_W = $clog2(LONG_CYCLES);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic ACT_LOW = (ACTIVE_LOW != 0);

  logic btn_sync;
  logic btn_a;

  // Synchronizer idles at the released pin level so reset never looks like a press.
  sync2 #(.RESET_VAL(ACT_LOW)) u_sync (
    .clk   (clk50mhz),
    .rst_n (reset_n),
    .d     (button),
    .q     (btn_sync)
  );

  assign btn_a = btn_sync ^ ACT_LOW;

  state_t              state_q, state_d;
  logic [DEB_W-1:0]    deb_cnt_q, deb_cnt_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic                from_long_q, from_long_d;
  logic                pressed_q, pressed_d;
  logic                press_pulse_q, press_pulse_d;
  logic                release_pulse_q, release_pulse_d;
  logic                long_pulse_q, long_pulse_d;
  mode_t               mode_q, mode_d;

  logic deb_done;
  logic hold_done;

  assign deb_done  = (deb_cnt_q == DEB_LAST);
  assign hold_done = (hold_cnt_q == HOLD_LAST);

  always_ff @(posedge clk50mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_IDLE;
      deb_cnt_q       <= '0;
      hold_cnt_q      <= '0;
      from_long_q     <= 1'b0;
      pressed_q       <= 1'b0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      long_pulse_q    <= 1'b0;
      mode_q          <= '0;
    end else begin
      state_q         <= state_d;
      deb_cnt_q       <= deb_cnt_d;
      hold_cnt_q      <= hold_cnt_d;
      from_long_q     <= from_long_d;
      pressed_q       <= pressed_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
      long_pulse_q    <= long_pulse_d;
      mode_q          <= mode_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    deb_cnt_d   = deb_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    from_long_d = from_long_q;
    case (state_q)
      ST_IDLE: begin
        if (btn_a) begin
          state_d   = ST_DB_PRESS;
          deb_cnt_d = '0;
        end
      end
      ST_DB_PRESS: begin
        if (!btn_a) begin
          state_d = ST_IDLE;
        end else if (deb_done) begin
          state_d    = ST_HELD;
          hold_cnt_d = '0;
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
      end
      ST_HELD: begin
        // Reaching the long threshold takes priority over a release in the same clock.
        if (hold_done) begin
          state_d = ST_LONG;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          if (!btn_a) begin
            state_d     = ST_DB_RELEASE;
            deb_cnt_d   = '0;
            from_long_d = 1'b0;
          end
        end
      end
      ST_LONG: begin
        if (!btn_a) begin
          state_d     = ST_DB_RELEASE;
          deb_cnt_d   = '0;
          from_long_d = 1'b1;
        end
      end
      ST_DB_RELEASE: begin
        // The hold counter is frozen here so a bounce resumes the hold where it left off.
        if (btn_a) begin
          state_d = from_long_q ? ST_LONG : ST_HELD;
        end else if (deb_done) begin
          state_d = ST_IDLE;
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    pressed_d       = pressed_q;
    press_pulse_d   = 1'b0;
    release_pulse_d = 1'b0;
    long_pulse_d    = 1'b0;
    mode_d          = mode_q;
    case (state_q)
      ST_DB_PRESS: begin
        if (btn_a && deb_done) begin
          press_pulse_d = 1'b1;
          pressed_d     = 1'b1;
        end
      end
      ST_HELD: begin
        if (hold_done) begin
          long_pulse_d = 1'b1;
          mode_d       = '0;
        end
      end
      ST_DB_RELEASE: begin
        if (!btn_a && deb_done) begin
          release_pulse_d = 1'b1;
          pressed_d       = 1'b0;
          if (!from_long_q) begin
            mode_d = mode_q + MODE_W'(1);
          end
        end
      end
      default: begin
      end
    endcase
  end

  assign pressed       = pressed_q;
  assign press_pulse   = press_pulse_q;
  assign release_pulse = release_pulse_q;
  assign long_pulse    = long_pulse_q;
  assign mode          = mode_q;

endmodule

// File: tb/tb_button_reader.sv
// Bench for button_reader: directed latency scenarios plus random pin activity,
// checked by a run-length reference model feeding an expected-event queue.
module tb_button_reader;

  localparam int D = 4;
  localparam int L = 20;
  localparam int W = 36;
  localparam int EV_PRESS = 1, EV_RELEASE = 2, EV_LONG = 3;

  logic       clk50mhz = 1'b0;
  logic       reset_n  = 1'b0;
  logic       button   = 1'b1;
  logic       pressed, press_pulse, release_pulse, long_pulse;
  logic [1:0] mode;

  always #5 clk50mhz = ~clk50mhz;

  button_reader #(
    .DEBOUNCE_CYCLES (D),
    .LONG_CYCLES     (L),
    .ACTIVE_LOW      (1)
  ) dut (
    .clk50mhz      (clk50mhz),
    .reset_n       (reset_n),
    .button        (button),
    .pressed       (pressed),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse),
    .mode          (mode)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  logic [W-1:0] exp_q[$];

  // Reference model: pin delay line plus run lengths of the active level.
  bit         m_s1, m_s2, m_deb, m_long;
  int         m_run, m_rrun, m_hold;
  logic [1:0] m_mode;

  function automatic void model_reset();
    m_s1 = 1'b1; m_s2 = 1'b1;
    m_deb = 1'b0; m_long = 1'b0;
    m_run = 0; m_rrun = 0; m_hold = 0;
    m_mode = 2'd0;
    exp_q.delete();
  endfunction

  function automatic void push_ev(input int code);
    exp_q.push_back({2'(code), m_mode, 32'(cyc)});
  endfunction

  function automatic void model_step(input logic pin);
    bit a;
    a = !m_s2;
    m_s2 = m_s1;
    m_s1 = pin;
    if (!m_deb) begin
      if (a) begin
        m_run++;
        if (m_run == D + 1) begin
          m_deb = 1'b1; m_run = 0; m_hold = 0; m_long = 1'b0; m_rrun = 0;
          push_ev(EV_PRESS);
        end
      end else begin
        m_run = 0;
      end
    end else if (m_rrun == 0 && !m_long) begin
      if (m_hold == L - 1) begin
        m_long = 1'b1;
        m_mode = 2'd0;
        push_ev(EV_LONG);
      end else begin
        m_hold++;
        if (!a) m_rrun = 1;
      end
    end else if (m_rrun == 0) begin
      if (!a) m_rrun = 1;
    end else begin
      if (a) begin
        m_rrun = 0;
      end else begin
        m_rrun++;
        if (m_rrun == D + 1) begin
          if (!m_long) m_mode = m_mode + 2'd1;
          m_deb = 1'b0; m_rrun = 0; m_long = 1'b0;
          push_ev(EV_RELEASE);
        end
      end
    end
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk50mhz or negedge reset_n);
      if (!reset_n) begin
        model_reset();
      end else begin
        cyc++;
        model_step(button);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every falling edge compare levels, and match any strobe to the queue head.
  initial begin
    int np;
    int code;
    logic [W-1:0] e;
    forever begin
      @(negedge clk50mhz);
      check("pressed_level", 32'(pressed), 32'(m_deb));
      check("mode_level", 32'(mode), 32'(m_mode));
      np = int'(press_pulse) + int'(release_pulse) + int'(long_pulse);
      if (np > 1) check("pulse_overlap", 32'(np), 32'd1);
      while (exp_q.size() > 0 && exp_q[0][31:0] < 32'(cyc)) begin
        e = exp_q.pop_front();
        tests++; fails++;
        $display("FAIL missed_event: got none, expected code %0d at cycle %0d", e[35:34], e[31:0]);
      end
      if (np >= 1) begin
        code = press_pulse ? EV_PRESS : (release_pulse ? EV_RELEASE : EV_LONG);
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_event: got code %0d at cycle %0d, expected none", code, cyc);
        end else begin
          e = exp_q.pop_front();
          check("event_code", 32'(code), 32'(e[35:34]));
          check("event_cycle", 32'(cyc), e[31:0]);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk50mhz);
  endtask

  function automatic logic pulse_of(input int which);
    case (which)
      EV_PRESS:   return press_pulse;
      EV_RELEASE: return release_pulse;
      default:    return long_pulse;
    endcase
  endfunction

  // k counts falling edges from the next rising edge; a strobe seen at k arose at edge k.
  task automatic wait_pulse(input int which, input int exp_edge, input string name);
    bit seen;
    int at;
    seen = 1'b0;
    at = -1;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk50mhz);
      if (pulse_of(which)) begin
        seen = 1'b1;
        at = k;
      end
    end
    check(name, 32'(at), 32'(exp_edge));
  endtask

  task automatic short_press(input int hold);
    button = 1'b0;
    idle(hold);
    button = 1'b1;
    idle(12);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog expired");
  end

  initial begin
    button  = 1'b1;
    reset_n = 1'b0;
    idle(3);
    check("reset_pressed", 32'(pressed), 32'd0);
    check("reset_pulses", 32'({press_pulse, release_pulse, long_pulse}), 32'd0);
    check("reset_mode", 32'(mode), 32'd0);
    #1 reset_n = 1'b1;
    idle(5);

    // Clean press and release, then wrap the mode counter
    button = 1'b0;
    wait_pulse(EV_PRESS, 6, "press_latency");
    idle(3);
    button = 1'b1;
    wait_pulse(EV_RELEASE, 6, "release_latency");
    check("mode_after_one", 32'(mode), 32'd1);
    idle(5);
    short_press(10);
    short_press(10);
    short_press(10);
    check("mode_wrap", 32'(mode), 32'd0);

    // Bounce shorter than the debounce window
    button = 1'b0;
    idle(3);
    button = 1'b1;
    idle(12);
    check("bounce_pressed", 32'(pressed), 32'd0);

    // Long hold entered with mode 2
    short_press(10);
    short_press(10);
    check("mode_before_long", 32'(mode), 32'd2);
    button = 1'b0;
    wait_pulse(EV_PRESS, 6, "long_press_latency");
    wait_pulse(EV_LONG, 19, "long_latency");
    check("mode_after_long", 32'(mode), 32'd0);
    idle(5);
    button = 1'b1;
    wait_pulse(EV_RELEASE, 6, "long_release_latency");
    check("mode_no_inc_long", 32'(mode), 32'd0);
    idle(5);

    // Two-clock glitch while held: hold counter resumes, long fires two clocks late
    button = 1'b0;
    wait_pulse(EV_PRESS, 6, "glitch_press_latency");
    idle(5);
    button = 1'b1;
    idle(2);
    button = 1'b0;
    wait_pulse(EV_LONG, 14, "glitch_long_latency");
    idle(3);
    button = 1'b1;
    wait_pulse(EV_RELEASE, 6, "glitch_release_latency");
    idle(5);

    // Reset during release debounce with mode 3
    short_press(10);
    short_press(10);
    short_press(10);
    check("mode_before_reset", 32'(mode), 32'd3);
    button = 1'b0;
    wait_pulse(EV_PRESS, 6, "pre_reset_press");
    idle(3);
    button = 1'b1;
    idle(4);
    #1 reset_n = 1'b0;
    #1;
    check("async_reset_pressed", 32'(pressed), 32'd0);
    check("async_reset_pulses", 32'({press_pulse, release_pulse, long_pulse}), 32'd0);
    check("async_reset_mode", 32'(mode), 32'd0);
    button = 1'b0;
    idle(3);
    #1 reset_n = 1'b1;
    wait_pulse(EV_PRESS, 6, "press_after_reset");
    idle(3);
    button = 1'b1;
    idle(12);

    // Random pin activity with occasional resets
    for (int i = 0; i < 150; i++) begin
      button = 1'($urandom_range(0, 1));
      idle($urandom_range(1, (i % 4 == 0) ? 45 : 8));
      if ($urandom_range(0, 29) == 0) begin
        #1 reset_n = 1'b0;
        idle(2);
        #1 reset_n = 1'b1;
      end
    end

    button = 1'b1;
    idle(40);
    check("events_outstanding", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
